// File: rtl/scan_mux_pkg.sv
// Shared encodings for the display scan multiplexer: operating modes and one-shot FSM states.
// Pure types and constants; no logic, no latency, no flow control.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL  = 2'b00,
        MODE_SCAN    = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_BLANK   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STOP = 2'b10
    } os_state_e;

endpackage

// File: rtl/scan_prescaler.sv
// Step prescaler: tick in the cycle the count reaches TICK_DIV-1; combinational tick, count registered.
// No backpressure; clr overrides run and suppresses tick, count held at 0 while not running.
module scan_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == CNT_LAST);
    assign tick    = run && !clr && at_last;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || !run || at_last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel display mux with manual, recycling scan, one-shot scan and blank modes.
// 1-clock latency on data, index and enable together; no backpressure, start honoured only in one-shot mode.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int TICK_DIV = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [1:0]                mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      start,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          ch_idx,
    output logic [CHANNELS-1:0]       ch_en,
    output logic                      done
);

    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(CHANNELS - 1);

    mode_e                mode_cur;
    mode_e                mode_q;
    os_state_e            state_q;
    os_state_e            state_d;
    logic [SEL_W-1:0]     ch_idx_q;
    logic [SEL_W-1:0]     next_idx;
    logic [WIDTH-1:0]     data_q;
    logic [WIDTH-1:0]     data_d;
    logic [CHANNELS-1:0]  ch_en_q;
    logic [CHANNELS-1:0]  ch_en_d;
    logic                 done_q;
    logic                 done_d;
    logic                 blank;
    logic                 mode_chg;
    logic                 start_acc;
    logic                 idx_at_last;
    logic [SEL_W-1:0]     idx_inc;
    logic                 pre_run;
    logic                 pre_clr;
    logic                 tick;
    logic [WIDTH-1:0]     ch_dat [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign ch_dat[k] = data_in[k*WIDTH +: WIDTH];
    end

    assign mode_cur    = mode_e'(mode);
    assign mode_chg    = (mode_cur != mode_q);
    assign start_acc   = start && (mode_cur == MODE_ONESHOT) && !mode_chg;
    assign idx_at_last = (ch_idx_q == IDX_LAST);
    // Wrap by comparison so non-power-of-2 channel counts never overflow into unused indices.
    assign idx_inc     = idx_at_last ? '0 : ch_idx_q + SEL_W'(1);

    assign pre_run = (mode_cur == MODE_SCAN) ||
                     ((mode_cur == MODE_ONESHOT) && (state_q == S_RUN));
    assign pre_clr = mode_chg || start_acc;

    scan_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (pre_run),
        .clr   (pre_clr),
        .tick  (tick)
    );

    always_comb begin
        next_idx = ch_idx_q;
        blank    = 1'b0;
        state_d  = state_q;
        done_d   = 1'b0;

        unique case (mode_cur)
            MODE_MANUAL: begin
                if (32'(sel) < CHANNELS) begin
                    next_idx = sel;
                end else begin
                    blank = 1'b1;
                end
            end
            MODE_SCAN: begin
                if (mode_chg) begin
                    next_idx = '0;
                end else if (tick) begin
                    next_idx = idx_inc;
                end
            end
            MODE_ONESHOT: begin
                if (mode_chg) begin
                    state_d  = S_IDLE;
                    next_idx = '0;
                    blank    = 1'b1;
                end else if (start) begin
                    // A restart beats a coincident tick.
                    state_d  = S_RUN;
                    next_idx = '0;
                end else begin
                    unique case (state_q)
                        S_RUN: begin
                            if (tick) begin
                                if (idx_at_last) begin
                                    state_d = S_STOP;
                                    done_d  = 1'b1;
                                end else begin
                                    next_idx = idx_inc;
                                end
                            end
                        end
                        S_STOP: begin
                            next_idx = IDX_LAST;
                            done_d   = 1'b1;
                        end
                        default: begin
                            state_d  = S_IDLE;
                            next_idx = '0;
                            blank    = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
                blank = 1'b1;
            end
        endcase

        if (mode_cur != MODE_ONESHOT) begin
            state_d = S_IDLE;
        end
    end

    assign data_d  = blank ? '0 : ch_dat[next_idx];
    assign ch_en_d = blank ? '0 : (CHANNELS'(1) << next_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_MANUAL;
            state_q  <= S_IDLE;
            ch_idx_q <= '0;
            data_q   <= '0;
            ch_en_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            mode_q   <= mode_cur;
            state_q  <= state_d;
            ch_idx_q <= next_idx;
            data_q   <= data_d;
            ch_en_q  <= ch_en_d;
            done_q   <= done_d;
        end
    end

    assign data_out = data_q;
    assign ch_idx   = ch_idx_q;
    assign ch_en    = ch_en_q;
    assign done     = done_q;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a time-based behavioural model.
module tb_scan_mux;

    localparam int W  = 4;
    localparam int C  = 4;
    localparam int SW = 2;
    localparam int TD = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [C*W-1:0]   data_in;
    logic [1:0]       mode;
    logic [SW-1:0]    sel;
    logic             start;
    logic [W-1:0]     data_out;
    logic [SW-1:0]    ch_idx;
    logic [C-1:0]     ch_en;
    logic             done;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    scan_mux #(
        .WIDTH    (W),
        .CHANNELS (C),
        .SEL_W    (SW),
        .TICK_DIV (TD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .mode     (mode),
        .sel      (sel),
        .start    (start),
        .data_out (data_out),
        .ch_idx   (ch_idx),
        .ch_en    (ch_en),
        .done     (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [W-1:0] chan(input logic [C*W-1:0] d, input int i);
        return d[i*W +: W];
    endfunction

    // Model: position in a scan is derived from edges elapsed since mode entry or start.
    int              m_prev;
    int              m_n;
    bit              m_act;
    logic [W-1:0]    e_dat;
    logic [SW-1:0]   e_idx;
    logic [C-1:0]    e_en;
    logic            e_done;

    always @(posedge clk or negedge rst_n) begin : model
        int md, n, k, ix;
        bit act, ent, blank, dn;
        if (!rst_n) begin
            m_prev <= -1;
            m_n    <= 0;
            m_act  <= 1'b0;
            e_dat  <= '0;
            e_idx  <= '0;
            e_en   <= '0;
            e_done <= 1'b0;
        end else begin
            md    = int'(mode);
            ent   = (md != m_prev);
            n     = m_n;
            act   = m_act;
            ix    = int'(e_idx);
            blank = 1'b0;
            dn    = 1'b0;
            case (md)
                0: begin
                    if (int'(sel) < C) ix = int'(sel);
                    else blank = 1'b1;
                end
                1: begin
                    n  = ent ? 0 : n + 1;
                    ix = (n / TD) % C;
                end
                2: begin
                    if (ent) act = 1'b0;
                    else if (start) begin
                        act = 1'b1;
                        n   = 0;
                    end else if (act) n = n + 1;
                    if (!act) begin
                        ix    = 0;
                        blank = 1'b1;
                    end else begin
                        k  = n / TD;
                        ix = (k < C) ? k : C - 1;
                        dn = (k >= C);
                    end
                end
                default: blank = 1'b1;
            endcase
            m_prev <= md;
            m_n    <= n;
            m_act  <= act;
            e_idx  <= SW'(ix);
            e_dat  <= blank ? '0 : chan(data_in, ix);
            e_en   <= blank ? '0 : C'(1 << ix);
            e_done <= dn;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_data_out", 32'(data_out), 32'(e_dat));
            chk("cyc_ch_idx",   32'(ch_idx),   32'(e_idx));
            chk("cyc_ch_en",    32'(ch_en),    32'(e_en));
            chk("cyc_done",     32'(done),     32'(e_done));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_data", 32'(data_out), 32'h0);
        chk("async_rst_en",   32'(ch_en),    32'h0);
        chk("async_rst_idx",  32'(ch_idx),   32'h0);
        chk("async_rst_done", 32'(done),     32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        rst_n   = 1'b0;
        mode    = 2'b01;
        sel     = '0;
        start   = 1'b0;
        data_in = 16'hDCBA;

        // Reset held while scan mode is requested
        step(3);
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_idx",  32'(ch_idx),   32'h0);
        chk("rst_en",   32'(ch_en),    32'h0);
        chk("rst_done", 32'(done),     32'h0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        step(7);
        mid_reset();
        step(1);
        chk("post_rst_idx",  32'(ch_idx),   32'h0);
        chk("post_rst_data", 32'(data_out), 32'hA);

        // Manual select and data pass-through latency
        mode = 2'b00;
        sel  = 2'd2;
        step(1);
        chk("man_data", 32'(data_out), 32'hC);
        chk("man_idx",  32'(ch_idx),   32'h2);
        chk("man_en",   32'(ch_en),    32'b0100);
        data_in = 16'hD7BA;
        step(1);
        chk("man_upd", 32'(data_out), 32'h7);
        data_in = 16'hDCBA;

        // Recycling scan: each channel held TD clocks, wraps to A
        mode = 2'b01;
        step(1);
        chk("scan_a",  32'(data_out), 32'hA);
        chk("scan_ea", 32'(ch_en),    32'b0001);
        step(3);
        chk("scan_b",  32'(data_out), 32'hB);
        chk("scan_eb", 32'(ch_en),    32'b0010);
        step(3);
        chk("scan_c",  32'(data_out), 32'hC);
        step(3);
        chk("scan_d",  32'(data_out), 32'hD);
        chk("scan_ed", 32'(ch_en),    32'b1000);
        step(3);
        chk("scan_wrap", 32'(data_out), 32'hA);
        chk("scan_done", 32'(done),     32'h0);

        // One-shot: idle, then a full pass ending sticky on D
        mode = 2'b10;
        step(2);
        chk("os_idle_en",   32'(ch_en), 32'h0);
        chk("os_idle_done", 32'(done),  32'h0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("os_first", 32'(data_out), 32'hA);
        step(11);
        chk("os_d",        32'(data_out), 32'hD);
        chk("os_pre_done", 32'(done),     32'h0);
        step(1);
        chk("os_done", 32'(done), 32'h1);
        step(10);
        chk("os_hold_idx",  32'(ch_idx),   32'h3);
        chk("os_hold_data", 32'(data_out), 32'hD);
        chk("os_hold_en",   32'(ch_en),    32'b1000);

        // Restart in the tick cycle at index 2
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(8);
        chk("os_at2", 32'(ch_idx), 32'h2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("os_rs_idx",  32'(ch_idx),   32'h0);
        chk("os_rs_data", 32'(data_out), 32'hA);
        chk("os_rs_done", 32'(done),     32'h0);
        step(2);
        chk("os_rs_hold", 32'(ch_idx), 32'h0);
        step(1);
        chk("os_rs_step", 32'(ch_idx), 32'h1);

        // Stop, then blank, then manual
        step(9);
        chk("os_stop2", 32'(done), 32'h1);
        mode = 2'b11;
        step(1);
        chk("blank_data", 32'(data_out), 32'h0);
        chk("blank_en",   32'(ch_en),    32'h0);
        chk("blank_done", 32'(done),     32'h0);
        chk("blank_idx",  32'(ch_idx),   32'h3);
        mode = 2'b00;
        sel  = 2'd3;
        step(1);
        chk("man_d", 32'(data_out), 32'hD);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = 1'b0;
            r = $urandom_range(0, 99);
            if (r < 4) mode = 2'($urandom_range(0, 3));
            else if (r < 14) sel = SW'($urandom_range(0, C - 1));
            if ($urandom_range(0, 9) == 0) start = 1'b1;
            if ($urandom_range(0, 19) == 0) data_in = 16'($urandom);
            if (i % 700 == 350) mid_reset();
        end
        start = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Registered, parametrised N-channel, WIDTH-bit multiplexer with four modes: manual select, recycling auto-scan, non-recycling one-shot scan, and blank.
- Drives the time-multiplexed digit display of the microwave controller. It replaces the fixed 2:1 combinational MUX.
- Data, channel index and one-hot enable update together on the same edge, so the display never shows one digit's data on another digit's position.

Parameters:
- WIDTH, 4, bits per channel.
- CHANNELS, 4, number of input channels (minimum 2).
- SEL_W, 2, select/index width; must equal $clog2(CHANNELS).
- TICK_DIV, 1000, clocks per scan step; minimum 1 (1 = step every cycle).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- data_in  input  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- mode  input  2  00 manual, 01 scan-recycle, 10 scan-one-shot, 11 blank
- sel  input  SEL_W  channel select, used in manual mode only
- start  input  1  one-cycle pulse; starts or restarts a one-shot scan
- data_out  output  WIDTH  registered selected data
- ch_idx  output  SEL_W  registered current channel index
- ch_en  output  CHANNELS  registered one-hot channel enable
- done  output  1  one-shot scan complete (sticky)

Behaviour:
- Reset (rst_n=0, asynchronous, effective immediately and mid-operation):
  - data_out=0, ch_idx=0, ch_en=0, done=0.
  - Prescaler=0; one-shot FSM=IDLE.
- Output timing:
  - Next index next_idx is computed combinationally.
  - On each edge: ch_idx<=next_idx, data_out<=data_in[next_idx], ch_en<=1<<next_idx.
  - Latency is 1 clock; data_in changes are also reflected with 1-clock latency.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps; tick=1 in the cycle the count equals TICK_DIV-1.
  - Runs only in mode 01, and in mode 10 while RUN; otherwise held at 0.
  - Cleared on any mode change and on an accepted start.
- Mode 00 (manual):
  - next_idx=sel.
  - If sel>=CHANNELS: data_out=0, ch_en=0, ch_idx holds its previous value.
- Mode 01 (recycle):
  - On entry, next_idx=0.
  - On tick, next_idx = (ch_idx==CHANNELS-1) ? 0 : ch_idx+1; otherwise hold.
- Mode 10 (one-shot), FSM states IDLE, RUN, STOP:
  - IDLE: ch_en=0, data_out=0, ch_idx=0, done=0. start -> RUN with next_idx=0, prescaler cleared.
  - RUN: on tick, if ch_idx<CHANNELS-1, increment. If ch_idx==CHANNELS-1, go to STOP and set done=1 on the same edge.
  - STOP: ch_idx=CHANNELS-1, outputs hold on the last channel, done stays 1; no wrap. start -> RUN at idx 0 with done=0.
  - start coincident with tick: start wins (idx 0, prescaler cleared, done=0).
  - Entering mode 10 from any other mode goes to IDLE.
- Mode 11 (blank): data_out=0, ch_en=0, ch_idx held.
- start is ignored outside mode 10.
- Any mode change clears done; new-mode behaviour appears at the next edge.
- Widths: ch_idx increment is SEL_W bits. For non-power-of-2 CHANNELS, wrap is by comparison, never by overflow.

Decomposition:
- Shared package/header: mode encodings MODE_MANUAL, MODE_SCAN, MODE_ONESHOT, MODE_BLANK; one-shot state encodings S_IDLE, S_RUN, S_STOP.
- One sub-module: scan_prescaler (parameter TICK_DIV; ports clk, rst_n, run, clr, tick). It is reused by the countdown timer.

Test Plan (CHANNELS=4, WIDTH=4, TICK_DIV=3, data_in=16'hDCBA, i.e. ch0=A, ch1=B, ch2=C, ch3=D):
1. Hold rst_n=0 while driving mode=01 -> data_out=0, ch_idx=0, ch_en=0000, done=0. Assert rst_n low mid-scan (between edges) -> outputs go 0 immediately. After release, scan resumes from idx 0.
2. mode=00, sel=2 -> one edge later: data_out=C, ch_idx=2, ch_en=0100. Change data_in ch2 to 7 -> data_out=7 after 1 clock.
3. mode=01 for 15 clocks -> data_out sequence A,B,C,D,A, each held 3 clocks; ch_en 0001,0010,0100,1000,0001; done stays 0.
4. mode=10, then start pulse -> A,B,C,D each 3 clocks. done=1 on the edge the step out of D would occur. Over 10 further clocks: data_out=D, ch_idx=3, ch_en=1000, no wrap.
5. One-shot RUN at idx 2, with start asserted in the tick cycle -> next edge: ch_idx=0, data_out=A, done=0, prescaler restarts (next step after 3 clocks).
6. In mode 10 STOP with done=1, switch mode to 11 -> next edge: data_out=0, ch_en=0000, done=0, ch_idx held at 3. Then mode=00, sel=3 -> data_out=D.
